// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: walks the sample history, multiplies each sample by its coefficient, accumulates, then rounds and shifts.
// Optional `define FIR_SAT_EN saturates the result to signed 32 bits instead of wrapping it.
module fir_tap_sequencer #(
    parameter int NTAPS = 66,
    parameter int SHIFT = 15,
    parameter int ACC_W = 72
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [6:0]         addr,
    input  logic signed [31:0] x_in,
    input  logic signed [31:0] c_in,
    output logic signed [31:0] y_out,
    output logic               done,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ROUND} state_t;

    localparam logic [6:0]                LAST = 7'(NTAPS - 1);
    localparam logic [ACC_W-1:0]          ONE  = 1;
    localparam logic signed [ACC_W-1:0]   RND  = (ONE << SHIFT) >> 1;

    state_t                   state, state_nxt;
    logic [6:0]               k, k_nxt;
    logic [1:0]               dcnt, dcnt_nxt;
    logic                     clr, fin;
    logic                     vld_p0, vld_p1, vld_p2;
    logic signed [31:0]       x_p1, c_p1;
    logic signed [63:0]       prod_p2;
    logic signed [ACC_W-1:0]  prod_ext, acc;

    // The +RND term rounds half up. RND is 0 when SHIFT is 0, so the same expression covers both cases.
    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        return (a + RND) >>> SHIFT;
    endfunction

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

    function automatic logic signed [31:0] reduce(input logic signed [ACC_W-1:0] r);
        if (r > SAT_MAX)
            return 32'sh7FFFFFFF;
        else if (r < SAT_MIN)
            return 32'sh80000000;
        else
            return r[31:0];
    endfunction
`else
    function automatic logic signed [31:0] reduce(input logic signed [ACC_W-1:0] r);
        return r[31:0];
    endfunction
`endif

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        dcnt_nxt  = dcnt;
        clr       = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    k_nxt     = 7'd0;
                    clr       = 1'b1;
                end
            end
            ISSUE: begin
                if (k == LAST) begin
                    state_nxt = DRAIN;
                    dcnt_nxt  = 2'd0;
                end else begin
                    k_nxt = k + 7'd1;
                end
            end
            DRAIN: begin
                if (dcnt == 2'd2)
                    state_nxt = ROUND;
                else
                    dcnt_nxt = dcnt + 2'd1;
            end
            ROUND: begin
                state_nxt = IDLE;
                fin       = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign addr     = (state == IDLE) ? 7'd0 : k;
    assign prod_ext = {{(ACC_W-64){prod_p2[63]}}, prod_p2};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= 7'd0;
            dcnt   <= 2'd0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            acc    <= '0;
            y_out  <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            dcnt   <= dcnt_nxt;
            // p0: the read data for an issued address arrives one cycle later
            vld_p0 <= (state == ISSUE);
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (clr)
                acc <= '0;
            else if (vld_p2)
                acc <= acc + prod_ext;
            if (fin)
                y_out <= reduce(round_shift(acc));
            done   <= fin;
            busy   <= (state != IDLE);
        end
    end

    // p1: capture operands; p2: registered product
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            x_p1 <= x_in;
            c_p1 <= c_in;
        end
        prod_p2 <= x_p1 * c_p1;
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: four instances with different NTAPS/SHIFT, each fed by a registered-read memory model.
module tb_fir_tap_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               start [4];
    logic [6:0]         addr  [4];
    logic signed [31:0] x_in  [4];
    logic signed [31:0] c_in  [4];
    logic signed [31:0] y_out [4];
    logic               done  [4];
    logic               busy  [4];

    logic signed [31:0] xm [4][128];
    logic signed [31:0] cm [4][128];
    int                 ntaps [4] = '{4, 1, 2, 66};
    int                 alog [0:127];
    int                 n_cmp = 0;
    int                 n_bad = 0;
    longint             exp66;
    int                 dones;

    always #5 clk = ~clk;

    fir_tap_sequencer #(.NTAPS(4), .SHIFT(0)) u_t4 (
        .clk(clk), .rst(rst), .start(start[0]), .addr(addr[0]), .x_in(x_in[0]),
        .c_in(c_in[0]), .y_out(y_out[0]), .done(done[0]), .busy(busy[0]));
    fir_tap_sequencer #(.NTAPS(1), .SHIFT(15)) u_t1 (
        .clk(clk), .rst(rst), .start(start[1]), .addr(addr[1]), .x_in(x_in[1]),
        .c_in(c_in[1]), .y_out(y_out[1]), .done(done[1]), .busy(busy[1]));
    fir_tap_sequencer #(.NTAPS(2), .SHIFT(0)) u_t2 (
        .clk(clk), .rst(rst), .start(start[2]), .addr(addr[2]), .x_in(x_in[2]),
        .c_in(c_in[2]), .y_out(y_out[2]), .done(done[2]), .busy(busy[2]));
    fir_tap_sequencer u_t66 (
        .clk(clk), .rst(rst), .start(start[3]), .addr(addr[3]), .x_in(x_in[3]),
        .c_in(c_in[3]), .y_out(y_out[3]), .done(done[3]), .busy(busy[3]));

    // History buffer and coefficient ROM: one-cycle registered read.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            x_in[i] <= xm[i][addr[i]];
            c_in[i] <= cm[i][addr[i]];
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a run on instance i, optionally re-pulsing start at cycle repulse, and check timing and result.
    task automatic run(input int i, input int repulse, input string tag, input longint exp_y);
        int lat;
        int bcnt;
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        alog[0] = int'(addr[i]);
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            start[i] = (n == repulse);
            if (n < 128) alog[n] = int'(addr[i]);
            if (busy[i]) bcnt++;
            if (done[i]) begin
                lat = n;
                break;
            end
        end
        start[i] = 1'b0;
        chk({tag, "_latency"}, lat, ntaps[i] + 4);
        chk({tag, "_busy_cycles"}, bcnt, ntaps[i] + 4);
        chk({tag, "_y"}, y_out[i], exp_y);
        @(posedge clk); #1;
        chk({tag, "_done_single"}, done[i], 0);
        chk({tag, "_busy_off"}, busy[i], 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            for (int j = 0; j < 128; j++) begin
                xm[i][j] = 0;
                cm[i][j] = 0;
            end
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_addr", addr[i], 0);
            chk("rst_done", done[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_y", y_out[i], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Impulse
        xm[0][0] = 1; xm[0][1] = 0; xm[0][2] = 0; xm[0][3] = 0;
        cm[0][0] = 5; cm[0][1] = 6; cm[0][2] = 7; cm[0][3] = 8;
        run(0, -1, "impulse", 5);

        // Full sum, with the address walk checked
        xm[0][0] = 1; xm[0][1] = 2; xm[0][2] = 3; xm[0][3] = 4;
        cm[0][0] = 1; cm[0][1] = 1; cm[0][2] = 1; cm[0][3] = 1;
        run(0, -1, "fullsum", 10);
        chk("addr_0", alog[0], 0);
        chk("addr_1", alog[1], 1);
        chk("addr_2", alog[2], 2);
        chk("addr_3", alog[3], 3);
        chk("addr_4", alog[4], 3);
        chk("addr_5", alog[5], 3);
        chk("addr_6", alog[6], 3);
        chk("addr_idle", alog[8], 0);

        // Rounding, NTAPS=1, SHIFT=15
        xm[1][0] = 3;  cm[1][0] = 16384;
        run(1, -1, "round_pos", 2);
        xm[1][0] = -3; cm[1][0] = 16384;
        run(1, -1, "round_neg", -1);

        // Saturation vs wrap
        xm[2][0] = 32'sh7FFFFFFF; xm[2][1] = 32'sh7FFFFFFF;
        cm[2][0] = 2; cm[2][1] = 2;
`ifdef FIR_SAT_EN
        run(2, -1, "sat", 32'sh7FFFFFFF);
`else
        run(2, -1, "wrap", -4);
`endif

        // Default 66 taps: reference model computed in the bench
        exp66 = 0;
        for (int j = 0; j < 66; j++) begin
            xm[3][j] = 1000 * (j + 1) - 7;
            cm[3][j] = (j * 37) % 201 - 100;
            exp66 += longint'(xm[3][j]) * longint'(cm[3][j]);
        end
        exp66 = longint'(int'((exp66 + 16384) >>> 15));
        run(3, 10, "start_ignored", exp66);
        run(3, -1, "back_to_back", exp66);

        // Reset mid-run
        start[3] = 1'b1;
        @(posedge clk); #1;
        start[3] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", busy[3], 0);
        chk("midrst_y", y_out[3], 0);
        dones = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk); #1;
            if (done[3]) dones++;
        end
        chk("midrst_no_done", dones, 0);
        chk("midrst_y_after", y_out[3], 0);
        run(3, -1, "after_reset", exp66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Read-side consumer of the 32-bit sample history line in the filter path.
- After each new sample is pushed, it walks the history address 0..NTAPS-1 and fetches each stored sample with 1-cycle registered read latency.
- Multiplies each sample by a coefficient fetched from an external coefficient ROM over the same address.
- Accumulates all taps, then rounds, shifts and outputs one filtered 32-bit result with a done pulse.

Parameters:
- NTAPS, 66, number of taps read per run (1..128).
- SHIFT, 15, arithmetic right shift applied to the accumulator (coefficient Q format); 0..31.
- ACC_W, 72, accumulator width in bits (>= 64 + ceil(log2(NTAPS))).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  run request; sampled only in IDLE.
- addr  out  7  tap index driven to the history buffer and the coefficient ROM.
- x_in  in  32  signed sample from the history buffer; valid 1 cycle after addr.
- c_in  in  32  signed coefficient from the ROM; valid 1 cycle after addr.
- y_out  out  32  signed filtered result; held until the next done.
- done  out  1  single-cycle pulse when y_out updates.
- busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive.

Behaviour:
- Reset is sync active-high.
  - All outputs 0, state IDLE, accumulator 0, pipeline valid flags 0.
  - Reset mid-run aborts the run; no done is produced.
- States: IDLE -> ISSUE -> DRAIN -> ROUND -> IDLE.
- IDLE:
  - addr=0.
  - start=1 at edge E0 clears the accumulator, sets tap count k=0 and moves to ISSUE.
  - start in any other state is ignored (no queuing).
- ISSUE (NTAPS cycles):
  - addr=k; k increments each cycle.
  - When k reaches NTAPS-1, move to DRAIN on the next edge.
  - A read-valid flag is delayed by 1 cycle to match buffer latency.
- Pipeline per tap:
  - Addr cycle t.
  - x_in and c_in captured at the end of t+1.
  - Signed 32x32 product registered (64b) at t+2.
  - Sign-extended product added to the accumulator at t+3.
  - Accumulator wraps at ACC_W bits; no overflow at legal parameters.
- DRAIN: 3 cycles; addr held at NTAPS-1; the pipeline empties.
- ROUND: 1 cycle.
  - If SHIFT>0: r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic); else r = acc.
  - r is reduced to 32 bits (see optional feature).
  - y_out is loaded and done=1 in this cycle; then return to IDLE.
- Latency: done is high exactly NTAPS+4 cycles after the E0 edge. For NTAPS=66 that is 70 cycles.
  - start may be re-asserted in the cycle after done.
- Upstream rule:
  - start must be issued at least 1 cycle after the push pulse to the history buffer.
  - During the push cycle the buffer returns the new sample regardless of address.
  - The sequencer does not check this.
- x_in and c_in are ignored when the read-valid flag is low.

Optional Feature:
- Macro FIR_SAT_EN.
- Defined: r is saturated to the signed 32-bit range [-2^31, 2^31-1].
- Undefined: r is truncated to its low 32 bits (two's-complement wrap).

Test Plan:
- Impulse (NTAPS=4, SHIFT=0): x={1,0,0,0}, c={5,6,7,8}, pulse start -> done at E0+8, y_out=5, busy high for 8 cycles.
- Full sum (NTAPS=4, SHIFT=0): x={1,2,3,4}, c={1,1,1,1} -> y_out=10.
  - addr sequence observed as 0,1,2,3 then held at 3 for 3 cycles.
- Rounding (NTAPS=1, SHIFT=15):
  - x=3, c=16384 -> acc=49152 -> y_out=2 (49152+16384=65536, >>15).
  - x=-3, c=16384 -> y_out=-1.
- Saturation (NTAPS=2, SHIFT=0): x={0x7FFFFFFF,0x7FFFFFFF}, c={2,2}.
  - With FIR_SAT_EN -> y_out=0x7FFFFFFF.
  - Without -> y_out=0xFFFFFFFC.
- start while busy (default NTAPS=66): start re-pulsed at E0+10 -> ignored; exactly one done at E0+70.
  - start at done+1 -> a second done at done+1+70.
- Reset mid-run: rst high at E0+5 for 1 cycle -> busy=0, done never pulses, y_out=0.
  - Next start produces a correct result.
